sram_arbiter: RTL

//  Shares the single external SRAM port among three requesters: VGA fetch (vram),

---
 rtl/sram_arbiter_if.sv | 63 ++++++
 rtl/sram_arbiter.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/sram_arbiter_if.sv
// rtl/sram_arbiter_if.sv - requester, sequencer and status signals of the SRAM arbiter
// slave is the arbiter's view; master is the view of the requesters and sequencer.
interface sram_arbiter_if #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 32
);
  logic              vram_req;
  logic              vram_write;
  logic [ADDR_W-1:0] vram_addr;
  logic [DATA_W-1:0] vram_wdata;
  logic              vram_ready;
  logic              vram_done;

  logic              mcr_req;
  logic              mcr_write;
  logic [ADDR_W-1:0] mcr_addr;
  logic [DATA_W-1:0] mcr_wdata;
  logic              mcr_ready;
  logic              mcr_done;

  logic              sdram_req;
  logic              sdram_write;
  logic [ADDR_W-1:0] sdram_addr;
  logic [DATA_W-1:0] sdram_wdata;
  logic              sdram_ready;
  logic              sdram_done;

  logic [DATA_W-1:0] rdata;

  logic              mem_req;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic              timeout_err;

  modport slave (
    input  vram_req, vram_write, vram_addr, vram_wdata,
    output vram_ready, vram_done,
    input  mcr_req, mcr_write, mcr_addr, mcr_wdata,
    output mcr_ready, mcr_done,
    input  sdram_req, sdram_write, sdram_addr, sdram_wdata,
    output sdram_ready, sdram_done,
    output rdata,
    output mem_req, mem_write, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata,
    output timeout_err
  );

  modport master (
    output vram_req, vram_write, vram_addr, vram_wdata,
    input  vram_ready, vram_done,
    output mcr_req, mcr_write, mcr_addr, mcr_wdata,
    input  mcr_ready, mcr_done,
    output sdram_req, sdram_write, sdram_addr, sdram_wdata,
    input  sdram_ready, sdram_done,
    input  rdata,
    input  mem_req, mem_write, mem_addr, mem_wdata,
    output mem_ack, mem_rdata,
    input  timeout_err
  );
endinterface

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - shares one SRAM sequencer port among vram, mcr and sdram requesters
// One access at a time: IDLE arbitrates, BUSY waits for mem_ack or timeout, DONE strobes the owner.
module sram_arbiter #(
  parameter int ADDR_W     = 18,
  parameter int DATA_W     = 32,
  parameter int VRAM_BURST = 4,
  parameter int TIMEOUT    = 63
) (
  input  logic           clk,
  input  logic           reset_n,
  sram_arbiter_if.slave  bus
);
  localparam int BW = $clog2(VRAM_BURST + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(VRAM_BURST);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_VRAM, OWN_MCR, OWN_SDRAM} owner_t;

  state_t            state;
  owner_t            owner;
  owner_t            pick;
  logic [BW-1:0]     burst_cnt;
  logic              rr_sdram;
  logic [TW-1:0]     tmo_cnt;
  logic              others;
  logic              sel_write;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [2:0]        own_oh;

  logic              mem_req_q;
  logic              mem_write_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              timeout_q;
  logic [2:0]        done_q;
  logic [2:0]        ready_q;

  // vram keeps priority until it has used its burst allowance against a waiting requester
  always_comb begin
    others = bus.mcr_req | bus.sdram_req;
    pick   = OWN_NONE;
    if (bus.vram_req && !(burst_cnt == BURST_MAX && others))
      pick = OWN_VRAM;
    else if (bus.mcr_req && bus.sdram_req)
      pick = rr_sdram ? OWN_SDRAM : OWN_MCR;
    else if (bus.mcr_req)
      pick = OWN_MCR;
    else if (bus.sdram_req)
      pick = OWN_SDRAM;

    sel_write = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    case (pick)
      OWN_VRAM: begin
        sel_write = bus.vram_write;
        sel_addr  = bus.vram_addr;
        sel_wdata = bus.vram_wdata;
      end
      OWN_MCR: begin
        sel_write = bus.mcr_write;
        sel_addr  = bus.mcr_addr;
        sel_wdata = bus.mcr_wdata;
      end
      OWN_SDRAM: begin
        sel_write = bus.sdram_write;
        sel_addr  = bus.sdram_addr;
        sel_wdata = bus.sdram_wdata;
      end
      default: ;
    endcase

    own_oh = 3'b000;
    case (owner)
      OWN_VRAM:  own_oh = 3'b001;
      OWN_MCR:   own_oh = 3'b010;
      OWN_SDRAM: own_oh = 3'b100;
      default:   own_oh = 3'b000;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      owner       <= OWN_NONE;
      burst_cnt   <= '0;
      rr_sdram    <= 1'b0;
      tmo_cnt     <= '0;
      mem_req_q   <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      timeout_q   <= 1'b0;
      done_q      <= '0;
      ready_q     <= '0;
    end else begin
      done_q  <= '0;
      ready_q <= '0;
      case (state)
        S_IDLE: begin
          if (pick != OWN_NONE) begin
            owner       <= pick;
            mem_req_q   <= 1'b1;
            mem_write_q <= sel_write;
            mem_addr_q  <= sel_addr;
            mem_wdata_q <= sel_wdata;
            tmo_cnt     <= '0;
            state       <= S_BUSY;
            if (pick == OWN_VRAM) begin
              burst_cnt <= others ? burst_cnt + 1'b1 : '0;
            end else begin
              burst_cnt <= '0;
              rr_sdram  <= (pick == OWN_MCR);
            end
          end
        end
        S_BUSY: begin
          if (bus.mem_ack) begin
            rdata_q   <= bus.mem_rdata;
            mem_req_q <= 1'b0;
            done_q    <= own_oh;
            ready_q   <= mem_write_q ? 3'b000 : own_oh;
            state     <= S_DONE;
          end else if (tmo_cnt == TMO_LAST) begin
            mem_req_q <= 1'b0;
            timeout_q <= 1'b1;
            done_q    <= own_oh;
            state     <= S_DONE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        S_DONE: begin
          owner <= OWN_NONE;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.mem_req     = mem_req_q;
  assign bus.mem_write   = mem_write_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.rdata       = rdata_q;
  assign bus.timeout_err = timeout_q;
  assign bus.vram_done   = done_q[0];
  assign bus.mcr_done    = done_q[1];
  assign bus.sdram_done  = done_q[2];
  assign bus.vram_ready  = ready_q[0];
  assign bus.mcr_ready   = ready_q[1];
  assign bus.sdram_ready = ready_q[2];
endmodule
